// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between N_REQ requesters. An idle arbiter picks
// one pending requester round-robin, latches its byte, and then drives the
// UART handshake: one LOAD cycle (byte_ready_o), one START cycle (t_byte_o),
// and a WAIT phase that lasts one full serial frame before it accepts again.
// Requests are only looked at while IDLE; nothing is queued.
//
// Parameters
//   N_REQ        number of requesters
//   CLKS_PER_BIT clock cycles per serial bit
//   FRAME_BITS   serial bits per frame (start + data + stop)
//
// Ports
//   clk          rising-edge clock
//   reset_i      asynchronous active-high reset
//   req_i        per-requester request, held until granted
//   data_i       byte of requester i on bits [8i+7:8i]
//   gnt_o        one-hot pulse during LOAD: that requester's byte was taken
//   byte_ready_o UART load strobe (LOAD cycle)
//   t_byte_o     UART start strobe (START cycle)
//   data_o       byte of the current grant, stable until the next grant
//   busy_o       high whenever the arbiter is not IDLE
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int FRAME_BITS   = 10
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [8*N_REQ-1:0] data_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic               byte_ready_o,
  output logic               t_byte_o,
  output logic [7:0]         data_o,
  output logic               busy_o
);

  localparam int FRAME_CLKS = FRAME_BITS * CLKS_PER_BIT;
  localparam int CW         = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
  localparam int IW         = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_CLKS - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    START,
    WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    last_q, last_d;
  logic [7:0]       data_q, data_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             byte_ready_q, byte_ready_d;
  logic             t_byte_q, t_byte_d;

  logic             any_req;
  logic [IW-1:0]    win_idx;
  logic [7:0]       win_data;
  int               cand;

  // Round-robin winner search. Candidates are visited from the farthest
  // position (last_q itself) back to the nearest (last_q+1), so the nearest
  // pending requester is the last one to overwrite the result and wins.
  always_comb begin
    any_req  = 1'b0;
    win_idx  = last_q;
    win_data = 8'h00;
    cand     = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = (int'(last_q) + k) % N_REQ;
      if (req_i[cand]) begin
        any_req  = 1'b1;
        win_idx  = IW'(cand);
        win_data = data_i[8*cand +: 8];
      end
    end
  end

  // Next-state and next-output logic. Strobes default low so each one is a
  // single-cycle pulse; data and last grant only change on an accept.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    data_d       = data_q;
    gnt_d        = '0;
    byte_ready_d = 1'b0;
    t_byte_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = LOAD;
          last_d       = win_idx;
          data_d       = win_data;
          gnt_d        = N_REQ'(1) << win_idx;
          byte_ready_d = 1'b1;
        end
      end
      LOAD: begin
        state_d  = START;
        t_byte_d = 1'b1;
        cnt_d    = '0;
      end
      START: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset leaves last_q at the top index so that
  // requester 0 is first in the search order after reset.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_q       <= IDX_LAST;
      data_q       <= 8'h00;
      gnt_q        <= '0;
      byte_ready_q <= 1'b0;
      t_byte_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      data_q       <= data_d;
      gnt_q        <= gnt_d;
      byte_ready_q <= byte_ready_d;
      t_byte_q     <= t_byte_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign byte_ready_o = byte_ready_q;
  assign t_byte_o     = t_byte_q;
  assign data_o       = data_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one UART transmitter.
REQ-002 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit, matching the Baudcount terminal count.
REQ-003 Parameter FRAME_BITS, default 10: bits per frame (start + 8 data + stop).
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port reset_i  input  1: asynchronous, active-high reset.
REQ-006 Port req_i  input  N_REQ: request i wants to send one byte; held until its grant.
REQ-007 Port data_i  input  8*N_REQ: byte of requester i on bits [8i+7:8i].
REQ-008 Port gnt_o  output  N_REQ: one-hot, one-cycle pulse; requester i's byte was accepted.
REQ-009 Port byte_ready_o  output  1: to UART byte_ready_i; load data_o into the data register.
REQ-010 Port t_byte_o  output  1: to UART t_byte_i; start transmission of the loaded byte.
REQ-011 Port data_o  output  8: to UART data_i; byte of the current grant.
REQ-012 Port busy_o  output  1: high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, START and WAIT, fully registered.
REQ-014 IDLE with req_i all zero: stay in IDLE; all outputs 0; data_o holds its last value.
REQ-015 IDLE with any req_i bit set: on the clock edge, select winner w round-robin, register data_o <= data_i[w], register gnt_o[w] <= 1, and go to LOAD.
REQ-016 Round-robin: search order starts at (last_grant+1) mod N_REQ and wraps; last_grant <= w on each grant.
REQ-017 LOAD (exactly 1 cycle): gnt_o[w]=1, byte_ready_o=1; next state START.
REQ-018 START (exactly 1 cycle): t_byte_o=1, gnt_o=0; frame counter cleared to 0; next state WAIT.
REQ-019 WAIT: frame counter increments every cycle; at count FRAME_BITS*CLKS_PER_BIT-1, go to IDLE.
REQ-020 Frame counter width SHALL be $clog2(FRAME_BITS*CLKS_PER_BIT); it SHALL never wrap within WAIT.
REQ-021 Accept-to-IDLE SHALL take exactly 2 + FRAME_BITS*CLKS_PER_BIT cycles (LOAD + START + WAIT).
REQ-022 At most one gnt_o bit SHALL be high in any cycle; byte_ready_o and t_byte_o SHALL never be high together.
REQ-023 Requests arriving while busy_o=1 SHALL be ignored and evaluated only on return to IDLE; no queueing.
REQ-024 A request withdrawn before its grant SHALL cause no transmission and no grant.
REQ-025 A request still high in the first IDLE cycle after its own WAIT is a new request and competes normally.
REQ-026 data_o SHALL stay stable from LOAD until the next grant, regardless of data_i changes.
REQ-027 Simultaneous requests SHALL be served in round-robin order, one frame each.

Reset
REQ-028 While reset_i=1, asynchronously: state=IDLE, gnt_o=0, byte_ready_o=0, t_byte_o=0, busy_o=0, data_o=8'h00, frame counter=0, last_grant=N_REQ-1 (requester 0 has first priority).
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately; after release the block SHALL be in IDLE and accept a new request in the first cycle.

Verification
REQ-030 Single request: req_i=4'b0100, data_i[23:16]=8'hA5 -> next cycle gnt_o=4'b0100, byte_ready_o=1, data_o=8'hA5; following cycle t_byte_o=1; busy_o low again exactly 162 cycles after accept.
REQ-031 All requesters held high from reset -> grants in order 0,1,2,3,0, each spaced 163 cycles apart (162 busy + 1 IDLE).
REQ-032 Requester 1 raises req_i during requester 3's WAIT -> no gnt_o until IDLE; then gnt_o=4'b0010.
REQ-033 reset_i pulsed at WAIT count 50 -> all outputs 0 in the same cycle; after release, req_i=4'b0001 -> grant to requester 0 one cycle later.
REQ-034 data_i[7:0] changed from 8'h3C to 8'hFF during WAIT of requester 0 -> data_o stays 8'h3C until the next grant.
REQ-035 Every cycle: gnt_o is one-hot or zero; byte_ready_o & t_byte_o == 0; busy_o == (state != IDLE).
